id_hazard_ctrl: RTL and testbench

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

---
 rtl/id_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_id_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: long-latency scoreboard, multi-cycle unit tracking,
// stall/bubble generation and taken-branch flush.
module id_hazard_ctrl #(
  parameter int unsigned MC_LAT  = 4,
  parameter int unsigned REG_NUM = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1_addr,
  input  logic [4:0]         id_rs2_addr,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [4:0]         id_rd_addr,
  input  logic               id_rd_we,
  input  logic               id_is_load,
  input  logic               id_is_mc,
  input  logic               ex_branch_taken,
  input  logic               wb_long_we,
  input  logic [4:0]         wb_rd_addr,
  output logic               pc_stall,
  output logic               ifid_stall,
  output logic               idex_bubble,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               mc_busy,
  output logic               mc_done,
  output logic [REG_NUM-1:0] sb_pending
);

  typedef enum logic [0:0] {McIdle, McBusy} mc_state_e;

  mc_state_e          state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [REG_NUM-1:0] sb_q, sb_d;
  logic [REG_NUM-1:0] clr_mask, set_mask, eff_sb;
  logic               data_haz, struct_haz, stall_raw, flush, issue;

  // Hazard detection sees this cycle's write-back clears so the consumer is
  // released in the same cycle the producer retires.
  always_comb begin
    clr_mask = '0;
    if (wb_long_we) clr_mask[wb_rd_addr] = 1'b1;
    eff_sb = sb_q & ~clr_mask;

    data_haz = id_valid &
               ((id_rs1_used & (id_rs1_addr != 5'd0) & eff_sb[id_rs1_addr]) |
                (id_rs2_used & (id_rs2_addr != 5'd0) & eff_sb[id_rs2_addr]));
    struct_haz = id_valid & id_is_mc & (state_q == McBusy) & (cnt_q > 4'd1);
    stall_raw  = data_haz | struct_haz;
    flush      = ex_branch_taken & ~rst;
    issue      = id_valid & ~stall_raw & ~ex_branch_taken & ~rst;

    set_mask = '0;
    if (issue && id_rd_we && (id_rd_addr != 5'd0) && (id_is_load || id_is_mc)) begin
      set_mask[id_rd_addr] = 1'b1;
    end
    // Set wins over a same-cycle clear of the same register.
    sb_d    = (sb_q & ~clr_mask) | set_mask;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_done = 1'b0;
    unique case (state_q)
      McIdle: begin
        if (issue && id_is_mc) begin
          state_d = McBusy;
          cnt_d   = 4'(MC_LAT);
        end
      end
      McBusy: begin
        if (cnt_q == 4'd1) begin
          mc_done = ~rst;
          if (issue && id_is_mc) begin
            cnt_d = 4'(MC_LAT);
          end else begin
            state_d = McIdle;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = McIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_stall    = stall_raw & ~flush & ~rst;
    ifid_stall  = pc_stall;
    idex_bubble = pc_stall;
    ifid_flush  = flush;
    idex_flush  = flush;
    mc_busy     = (state_q == McBusy) & ~rst;
    sb_pending  = sb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= McIdle;
      cnt_q   <= 4'd0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl (MC_LAT=4, REG_NUM=32).
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_mc;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
  logic        ex_branch_taken, wb_long_we;
  logic        pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, mc_busy, mc_done;
  logic [31:0] sb_pending;

  int tests = 0;
  int fails = 0;

  id_hazard_ctrl #(.MC_LAT(4), .REG_NUM(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd_addr      (id_rd_addr),
    .id_rd_we        (id_rd_we),
    .id_is_load      (id_is_load),
    .id_is_mc        (id_is_mc),
    .ex_branch_taken (ex_branch_taken),
    .wb_long_we      (wb_long_we),
    .wb_rd_addr      (wb_rd_addr),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_bubble     (idex_bubble),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .mc_busy         (mc_busy),
    .mc_done         (mc_done),
    .sb_pending      (sb_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rd_we = 0;
    id_is_load = 0; id_is_mc = 0; ex_branch_taken = 0; wb_long_we = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; wb_rd_addr = 0;
  endtask

  // Inputs change 1 time unit after the edge, checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    id_valid = 1; ex_branch_taken = 1; id_is_mc = 1; id_rs1_used = 1; id_rs1_addr = 5'd3;
    settle();
    chk("rst_flush", {30'd0, ifid_flush, idex_flush}, 32'h0);
    chk("rst_stall", {29'd0, pc_stall, ifid_stall, idex_bubble}, 32'h0);
    tick();
    tick();
    chk("rst_busy_done", {30'd0, mc_busy, mc_done}, 32'h0);
    chk("rst_sb", sb_pending, 32'h0);
    rst = 0;
    idle();
    settle();

    // Load x5, dependent ADD stalls until the write-back of x5.
    id_valid = 1; id_is_load = 1; id_rd_we = 1; id_rd_addr = 5'd5;
    settle();
    chk("load_issue_nostall", {31'd0, pc_stall}, 32'h0);
    tick();
    chk("sb_x5_set", sb_pending, 32'h0000_0020);
    id_is_load = 0; id_rd_addr = 5'd6; id_rs1_used = 1; id_rs1_addr = 5'd5;
    settle();
    chk("raw_stall_c1", {29'd0, pc_stall, ifid_stall, idex_bubble}, 32'h7);
    tick();
    chk("raw_stall_c2", {31'd0, pc_stall}, 32'h1);
    wb_long_we = 1; wb_rd_addr = 5'd5;
    settle();
    chk("raw_release_same_cycle", {29'd0, pc_stall, ifid_stall, idex_bubble}, 32'h0);
    tick();
    idle();
    settle();
    chk("sb_x5_cleared", sb_pending, 32'h0);

    // Load to x0 never marks x0.
    id_valid = 1; id_is_load = 1; id_rd_we = 1; id_rd_addr = 5'd0;
    tick();
    chk("sb_x0_zero", sb_pending, 32'h0);
    idle();
    id_valid = 1; id_rs1_used = 1; id_rs1_addr = 5'd0;
    settle();
    chk("x0_no_stall", {31'd0, pc_stall}, 32'h0);
    tick();

    // Same-cycle set and clear of x9 leaves it pending.
    idle();
    id_valid = 1; id_is_load = 1; id_rd_we = 1; id_rd_addr = 5'd9;
    wb_long_we = 1; wb_rd_addr = 5'd9;
    tick();
    idle();
    settle();
    chk("set_beats_clear_x9", sb_pending, 32'h0000_0200);
    wb_long_we = 1; wb_rd_addr = 5'd9;
    tick();
    idle();
    settle();
    chk("x9_cleared", sb_pending, 32'h0);

    // id_valid=0 never stalls even with a pending source.
    id_valid = 1; id_is_load = 1; id_rd_we = 1; id_rd_addr = 5'd2;
    tick();
    idle();
    id_rs1_used = 1; id_rs1_addr = 5'd2;
    settle();
    chk("invalid_no_stall", {31'd0, pc_stall}, 32'h0);
    wb_long_we = 1; wb_rd_addr = 5'd2;
    tick();
    idle();
    settle();

    // MUL x3, then MUL x4 arriving in busy cycle 2 issues back-to-back.
    id_valid = 1; id_is_mc = 1; id_rd_we = 1; id_rd_addr = 5'd3;
    settle();
    chk("mul1_pre_busy", {31'd0, mc_busy}, 32'h0);
    tick();
    idle();
    settle();
    chk("mul_c1", {30'd0, mc_busy, mc_done}, 32'h2);
    chk("sb_x3", sb_pending, 32'h0000_0008);
    tick();
    id_valid = 1; id_is_mc = 1; id_rd_we = 1; id_rd_addr = 5'd4;
    settle();
    chk("mul_c2_struct_stall", {29'd0, pc_stall, mc_busy, mc_done}, 32'h6);
    tick();
    chk("mul_c3_struct_stall", {29'd0, pc_stall, mc_busy, mc_done}, 32'h6);
    tick();
    chk("mul_c4_done_issue", {29'd0, pc_stall, mc_busy, mc_done}, 32'h3);
    tick();
    idle();
    settle();
    chk("mul2_reload", {30'd0, mc_busy, mc_done}, 32'h2);
    chk("sb_x3_x4", sb_pending, 32'h0000_0018);

    // Reset when count reaches 2: op abandoned without completion.
    tick();
    tick();
    chk("mul2_cnt2_no_done", {30'd0, mc_busy, mc_done}, 32'h2);
    rst = 1;
    settle();
    chk("rst_gates_busy", {30'd0, mc_busy, mc_done}, 32'h0);
    tick();
    rst = 0;
    settle();
    chk("post_rst_idle", {30'd0, mc_busy, mc_done}, 32'h0);
    chk("post_rst_sb", sb_pending, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_late_done", {30'd0, mc_busy, mc_done}, 32'h0);
    end

    // Stall on x7 overridden by a taken branch; nothing issues.
    id_valid = 1; id_is_load = 1; id_rd_we = 1; id_rd_addr = 5'd7;
    tick();
    idle();
    id_valid = 1; id_rs2_used = 1; id_rs2_addr = 5'd7;
    id_is_mc = 1; id_rd_we = 1; id_rd_addr = 5'd8;
    settle();
    chk("x7_stall_no_branch", {31'd0, pc_stall}, 32'h1);
    ex_branch_taken = 1;
    settle();
    chk("branch_flush", {30'd0, ifid_flush, idex_flush}, 32'h3);
    chk("branch_overrides_stall", {29'd0, pc_stall, ifid_stall, idex_bubble}, 32'h0);
    tick();
    idle();
    settle();
    chk("branch_sb_unchanged", sb_pending, 32'h0000_0080);
    chk("branch_no_fsm_load", {31'd0, mc_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
